// File: rtl/parallel_to_serial_if.sv
// Row handshake and serial output bundle between the row feeder and its neighbours.
// The master side offers rows and stalls the shifter; the slave side is the serializer.
interface parallel_to_serial_if #(
  parameter int data_size = 64
) ();
  logic [data_size-1:0] ROW_IN;
  logic                 ROW_VALID;
  logic                 ROW_READY;
  logic                 HOLD;
  logic                 DATA_OUT;
  logic                 SHIFT_EN;
  logic                 BUSY;
  logic                 ROW_DONE;

  modport master (
    output ROW_IN,
    output ROW_VALID,
    output HOLD,
    input  ROW_READY,
    input  DATA_OUT,
    input  SHIFT_EN,
    input  BUSY,
    input  ROW_DONE
  );

  modport slave (
    input  ROW_IN,
    input  ROW_VALID,
    input  HOLD,
    output ROW_READY,
    output DATA_OUT,
    output SHIFT_EN,
    output BUSY,
    output ROW_DONE
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Row serializer for the Life datapath: takes a full row over valid/ready and emits it
// MSB first, one bit per SHIFT_EN strobe, with a one-row pending buffer for gapless streaming.
module parallel_to_serial #(
  parameter int data_size = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  parallel_to_serial_if.slave  bus
);

  localparam int                CNT_W    = $clog2(data_size);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(data_size - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [data_size-1:0] r_shreg;
  logic [data_size-1:0] w_shreg_nxt;
  logic [data_size-1:0] r_pend;
  logic [data_size-1:0] w_pend_nxt;
  logic                 r_pend_valid;
  logic                 w_pend_valid_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_done;
  logic                 w_done_nxt;

  logic                 w_shift_en;
  logic                 w_last;
  logic                 w_hs;

  // HOLD reaches SHIFT_EN combinationally so a stall takes effect in the same cycle.
  assign w_shift_en = (r_state == S_SHIFT) && !bus.HOLD;
  assign w_last     = w_shift_en && (r_cnt == CNT_LAST);
  assign w_hs       = bus.ROW_VALID && !r_pend_valid;

  // Next-state and datapath decode; loads override the default shift.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    w_cnt_nxt        = r_cnt;
    w_done_nxt       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_shreg_nxt = bus.ROW_IN;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_SHIFT: begin
        if (w_shift_en) begin
          w_shreg_nxt = {r_shreg[data_size-2:0], 1'b0};
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt   = r_cnt;
        end

        if (w_last) begin
          w_cnt_nxt  = CNT_ZERO;
          w_done_nxt = 1'b1;
          if (r_pend_valid) begin
            w_shreg_nxt      = r_pend;
            w_pend_valid_nxt = 1'b0;
          end else if (w_hs) begin
            // Row offered exactly on the last bit bypasses the pending slot.
            w_shreg_nxt = bus.ROW_IN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_hs) begin
          w_pend_nxt       = bus.ROW_IN;
          w_pend_valid_nxt = 1'b1;
        end else begin
          w_pend_valid_nxt = r_pend_valid;
        end
      end

      default: begin
        w_state_nxt      = S_IDLE;
        w_pend_valid_nxt = 1'b0;
        w_cnt_nxt        = CNT_ZERO;
      end
    endcase
  end

  // State register; reset discards both the in-flight and the pending row.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_shreg      <= {data_size{1'b0}};
      r_pend       <= {data_size{1'b0}};
      r_pend_valid <= 1'b0;
      r_cnt        <= CNT_ZERO;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_cnt        <= w_cnt_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign bus.DATA_OUT  = r_shreg[data_size-1];
  assign bus.SHIFT_EN  = w_shift_en;
  assign bus.BUSY      = (r_state == S_SHIFT);
  assign bus.ROW_DONE  = r_done;
  assign bus.ROW_READY = !r_pend_valid;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: a constant vector table, directed corner sequences and
// random traffic checked against a queue-of-bits model of the serial stream.
module tb_parallel_to_serial;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  parallel_to_serial_if #(.data_size(W)) bus ();

  parallel_to_serial #(.data_size(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int se_cnt = 0;
  int last_done_cyc = -1;
  logic [W-1:0] sp = '0;

  // Reference: the bits still to be sent, rows waiting, and the pulse owed for next cycle.
  bit           m_cur[$];
  logic [W-1:0] m_pend[$];
  bit           m_done = 1'b0;

  typedef struct {
    logic         v;
    logic [W-1:0] r;
    logic         h;
    logic         se;
    logic         dout;
    logic         done;
    logic         rdy;
  } vec_t;
  vec_t tbl[11];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void m_load(input logic [W-1:0] row);
    for (int i = W - 1; i >= 0; i--) m_cur.push_back(row[i]);
  endfunction

  task automatic apply(input logic v, input logic [W-1:0] r, input logic h);
    bit e_busy;
    @(negedge CLK);
    bus.ROW_VALID = v;
    bus.ROW_IN    = r;
    bus.HOLD      = h;
    #1;
    e_busy = (m_cur.size() != 0);
    chk1("busy", bus.BUSY, e_busy);
    chk1("shift_en", bus.SHIFT_EN, e_busy && !h);
    chk1("data_out", bus.DATA_OUT, e_busy ? m_cur[0] : 1'b0);
    chk1("row_ready", bus.ROW_READY, m_pend.size() == 0);
    chk1("row_done", bus.ROW_DONE, m_done);
    if (bus.ROW_DONE === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (bus.SHIFT_EN === 1'b1) begin
      se_cnt++;
      sp = {sp[W-2:0], bus.DATA_OUT};
    end
  endtask

  task automatic tick();
    bit hs;
    bit se;
    hs = bus.ROW_VALID && (m_pend.size() == 0);
    se = (m_cur.size() != 0) && !bus.HOLD;
    m_done = 1'b0;
    if (se) begin
      void'(m_cur.pop_front());
      if (m_cur.size() == 0) begin
        m_done = 1'b1;
        if (m_pend.size() != 0) begin
          m_load(m_pend.pop_front());
        end else if (hs) begin
          m_load(bus.ROW_IN);
          hs = 1'b0;
        end
      end
    end
    if (hs) begin
      if (m_cur.size() == 0) m_load(bus.ROW_IN);
      else m_pend.push_back(bus.ROW_IN);
    end
    @(posedge CLK);
    cyc++;
  endtask

  task automatic step(input logic v, input logic [W-1:0] r, input logic h);
    apply(v, r, h);
    tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bus.ROW_VALID = 1'b0;
    bus.ROW_IN    = '0;
    bus.HOLD      = 1'b0;
    #1;
    chk1("rst_data_out", bus.DATA_OUT, 1'b0);
    chk1("rst_shift_en", bus.SHIFT_EN, 1'b0);
    chk1("rst_busy", bus.BUSY, 1'b0);
    chk1("rst_row_done", bus.ROW_DONE, 1'b0);
    chk1("rst_row_ready", bus.ROW_READY, 1'b1);
    m_cur.delete();
    m_pend.delete();
    m_done = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    int h0;
    int d0;
    int s0;
    logic [W-1:0] a5;
    a5 = 8'hA5;
    bus.ROW_VALID = 1'b0;
    bus.ROW_IN    = '0;
    bus.HOLD      = 1'b0;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b1, a5[W-i], 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    do_reset();

    // Single row 0xA5 from idle against constant expectations.
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].v, tbl[i].r, tbl[i].h);
      chk1("tbl_shift_en", bus.SHIFT_EN, tbl[i].se);
      chk1("tbl_data_out", bus.DATA_OUT, tbl[i].dout);
      chk1("tbl_row_done", bus.ROW_DONE, tbl[i].done);
      chk1("tbl_row_ready", bus.ROW_READY, tbl[i].rdy);
      tick();
    end
    chk_int("tbl_deser", int'(sp), 32'hA5);

    // Back-to-back rows through the pending slot.
    h0 = cyc;
    step(1'b1, 8'hA5, 1'b0);
    s0 = se_cnt;
    d0 = done_cnt;
    step(1'b1, 8'h3C, 1'b0);
    for (int k = 2; k <= 18; k++) begin
      apply(1'b0, 8'h00, 1'b0);
      chk1("b2b_ready", bus.ROW_READY, (k > 8));
      tick();
    end
    chk_int("b2b_shift_cnt", se_cnt - s0, 16);
    chk_int("b2b_done_cnt", done_cnt - d0, 2);
    chk_int("b2b_done_cyc", last_done_cyc - h0, 17);
    chk_int("b2b_deser", int'(sp), 32'h3C);

    // Three-cycle HOLD starting at bit 4 of 0xFF.
    h0 = cyc;
    step(1'b1, 8'hFF, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 8'h00, 1'b0);
    for (int k = 5; k <= 7; k++) begin
      apply(1'b0, 8'h00, 1'b1);
      chk1("hold_data_out", bus.DATA_OUT, 1'b1);
      chk1("hold_shift_en", bus.SHIFT_EN, 1'b0);
      tick();
    end
    for (int k = 8; k <= 13; k++) step(1'b0, 8'h00, 1'b0);
    chk_int("hold_done_cyc", last_done_cyc - h0, 12);

    // HOLD on the last bit of 0x01.
    h0 = cyc;
    step(1'b1, 8'h01, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b0, 8'h00, 1'b0);
    for (int k = 8; k <= 9; k++) begin
      apply(1'b0, 8'h00, 1'b1);
      chk1("lasthold_data_out", bus.DATA_OUT, 1'b1);
      chk1("lasthold_row_done", bus.ROW_DONE, 1'b0);
      tick();
    end
    for (int k = 10; k <= 12; k++) step(1'b0, 8'h00, 1'b0);
    chk_int("lasthold_done_cyc", last_done_cyc - h0, 11);

    // Reset mid-row with a row pending, then a clean 0x81.
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    chk1("pre_rst_ready", bus.ROW_READY, 1'b0);
    d0 = done_cnt;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 1'b0);
    chk_int("rst_no_done", done_cnt - d0, 0);
    h0 = cyc;
    step(1'b1, 8'h81, 1'b0);
    for (int k = 1; k <= 10; k++) step(1'b0, 8'h00, 1'b0);
    chk_int("rst_deser", int'(sp), 32'h81);
    chk_int("rst_done_cyc", last_done_cyc - h0, 9);

    // 0x55 handshaken on the last-bit edge of 0xAA.
    h0 = cyc;
    d0 = done_cnt;
    step(1'b1, 8'hAA, 1'b0);
    s0 = se_cnt;
    for (int k = 1; k <= 7; k++) step(1'b0, 8'h00, 1'b0);
    apply(1'b1, 8'h55, 1'b0);
    chk1("direct_ready", bus.ROW_READY, 1'b1);
    tick();
    apply(1'b0, 8'h00, 1'b0);
    chk1("direct_no_gap", bus.SHIFT_EN, 1'b1);
    chk1("direct_pend_empty", bus.ROW_READY, 1'b1);
    tick();
    for (int k = 10; k <= 17; k++) step(1'b0, 8'h00, 1'b0);
    chk_int("direct_shift_cnt", se_cnt - s0, 16);
    chk_int("direct_done_cnt", done_cnt - d0, 2);
    chk_int("direct_deser", int'(sp), 32'h55);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Upstream feeder for the serial-to-parallel row shift register in the Life datapath. Accepts a full board row over a valid/ready handshake and shifts it out one bit per cycle, MSB first, with a shift-enable strobe. The downstream shift register therefore holds the original row after `data_size` strobes. A one-entry pending buffer lets the next row be accepted while the current row shifts, so back-to-back rows stream with no idle cycles.

## Interface
- `data_size`, default 64, row width in bits; must be ≥ 2.
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `ROW_IN`  in  data_size  parallel row; sampled on handshake.
- `ROW_VALID`  in  1  upstream has a row on `ROW_IN`.
- `ROW_READY`  out  1  block can accept a row; equals NOT pending-full.
- `HOLD`  in  1  downstream stall; freezes shifting while high.
- `DATA_OUT`  out  1  current serial bit; MSB of the shift register.
- `SHIFT_EN`  out  1  bit on `DATA_OUT` is valid this cycle; drives downstream `EN`.
- `BUSY`  out  1  shifter holds a row that is not fully sent.
- `ROW_DONE`  out  1  one-cycle pulse after the last bit of a row is consumed.

## Operation
- State: shift register `shreg[data_size]`, bit counter `cnt` of width `$clog2(data_size)`, `busy` flag, pending register `pend[data_size]` with `pend_valid`, and `ROW_DONE` register.
- Two states, implied by `busy`:
  - IDLE (`busy`=0): `SHIFT_EN`=0.
  - SHIFT (`busy`=1): `SHIFT_EN` = NOT `HOLD`. This path is combinational from `HOLD`.
- A bit is consumed on each edge where `SHIFT_EN`=1. On that edge, `shreg` shifts left by one, filling with 0, and `cnt` increments.
- Last-bit edge: `SHIFT_EN`=1 and `cnt`=data_size-1. On it, `cnt` clears to 0 and `ROW_DONE` is set for the following cycle. Then:
  - if `pend_valid`: `shreg`←`pend`, `pend_valid`←0, `busy` stays 1;
  - else if a handshake occurs on the same edge: `shreg`←`ROW_IN`, `busy` stays 1;
  - else `busy`←0.
- Handshake: `ROW_VALID`=1 and `ROW_READY`=1 on an edge.
  - If `busy`=0, or this is a last-bit edge with `pend_valid`=0: `ROW_IN` loads directly into `shreg` and `busy`←1.
  - Otherwise `ROW_IN` loads into `pend` and `pend_valid`←1.
- `ROW_READY` = NOT `pend_valid`. Rows offered while `ROW_READY`=0 are not taken; upstream holds them.
- `DATA_OUT` = `shreg[data_size-1]`.

## Timing
- Reset values, with all outputs forced immediately while `RST` is high:
  - `shreg`=0, `cnt`=0, `busy`=0, `pend_valid`=0;
  - `DATA_OUT`=0, `SHIFT_EN`=0, `BUSY`=0, `ROW_DONE`=0, `ROW_READY`=1.
- Handshakes are ignored while `RST` is high.
- Latency from an idle handshake at edge e: first bit valid, with `SHIFT_EN`=1, in the cycle after e. The last bit is valid data_size cycles later absent `HOLD`. `ROW_DONE` is high in the cycle after the last-bit edge.
- Throughput: one bit per cycle. Consecutive rows have zero gap when the next row is pending, or is handshaken on the last-bit edge.
- `HOLD`:
  - No bit is consumed, `cnt`/`shreg` are frozen, and `DATA_OUT` is stable.
  - `HOLD` on the last bit delays `ROW_DONE` until the bit is actually consumed.
  - Handshakes into `pend` remain allowed during `HOLD`.
- `HOLD` while idle has no effect.
- `ROW_DONE` is exactly one cycle per row, even when the next row starts on the same edge.
- Reset mid-row aborts both the in-flight and the pending row. No `ROW_DONE` is produced for either.
- Load takes priority over the default shift on any edge where both apply.

## Test plan
- data_size=8, idle, handshake `ROW_IN`=0xA5 -> `DATA_OUT` = 1,0,1,0,0,1,0,1 on 8 consecutive `SHIFT_EN` cycles. `ROW_DONE` pulses in the 9th cycle after the handshake. The downstream serial-to-parallel instance then reads 0xA5.
- Rows 0xA5 then 0x3C offered back-to-back with `ROW_VALID` held -> second row goes to pending and `ROW_READY`=0 until the edge that consumes bit 7 of 0xA5. 16 contiguous `SHIFT_EN` cycles follow, with two `ROW_DONE` pulses 8 cycles apart; downstream reads 0x3C at the end.
- `HOLD`=1 for 3 cycles starting at bit 4 of 0xFF -> `SHIFT_EN`=0 and `DATA_OUT`=1 held. Total duration is 11 cycles and `ROW_DONE` is delayed by 3.
- `HOLD`=1 on the last bit of 0x01 -> `DATA_OUT`=1 is held with no `ROW_DONE` until `HOLD` drops. The pulse then appears on the following cycle.
- `RST` asserted mid-row at bit 3, with a pending row present -> all outputs are at reset values immediately, and `ROW_READY`=1 after release. A new row 0x81 then serializes correctly with no stale bits.
- Handshake of 0x55 on the exact last-bit edge of 0xAA with pending empty -> direct load, no gap cycle, one `ROW_DONE` for 0xAA, and `pend_valid` remains 0.
